// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the power-up reset sequencer: FSM state encoding
// and the width helpers used to size its counters.
package reset_sequencer_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      WAIT_LOCK = 2'd0,
      RELEASE   = 2'd1,
      RUN       = 2'd2,
      HOLD      = 2'd3
   } seq_state_e;

   // Bits needed to hold values 0 .. value-1, never less than one bit.
   function automatic int clog2(input int value);
      int width;
      width = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) width = i + 1;
      end
      return width;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and its surroundings.
// The master side owns lock, software reset and flag clear; the sequencer
// (slave) drives the staged resets and status.
interface reset_sequencer_if
   import reset_sequencer_pkg::*;
#(
   parameter int NUM_STAGES = 3
);
   logic                  pll_locked;
   logic                  sw_reset;
   logic                  clear_lost;
   logic [NUM_STAGES-1:0] rst_n_out;
   logic                  done;
   logic [STATE_W-1:0]    state;
   logic                  lock_lost;

   modport master (
      output pll_locked, sw_reset, clear_lost,
      input  rst_n_out, done, state, lock_lost
   );

   modport slave (
      input  pll_locked, sw_reset, clear_lost,
      output rst_n_out, done, state, lock_lost
   );
endinterface

// File: rtl/reset_sequencer_sync_2ff.sv
// Single-bit two-flop synchroniser, reset to 0. Used for the PLL lock and
// intended for the other slow cross-domain flags as well.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta_q;
   logic sync_q;

   // Two back-to-back flops give the first stage a full cycle to settle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;
endmodule

// File: rtl/reset_sequencer.sv
// Power-up reset sequencer: waits for a filtered PLL lock, then releases
// NUM_STAGES active-low resets one STAGE_DELAY apart (bit 0 first).
// Lock loss and software reset requests pull everything back down.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   WAIT_LOCK | all resets held, counting consecutive lock_s highs
//   RELEASE   | releasing stages one by one, counter times the gap
//   RUN       | all stages released, watching for lock loss / sw reset
//   HOLD      | software reset: resets held for SW_HOLD cycles
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int NUM_STAGES    = 3,
   parameter int STAGE_DELAY   = 64,
   parameter int LOCK_FILTER   = 16,
   parameter int SW_HOLD       = 32,
   parameter int REARM_ON_LOSS = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   reset_sequencer_if.slave  bus
);

   localparam int CNT_W = clog2(max3(STAGE_DELAY, LOCK_FILTER, SW_HOLD) + 1);
   localparam int IDX_W = clog2(NUM_STAGES + 1);

   localparam logic [CNT_W-1:0] LOCK_TC  = CNT_W'(LOCK_FILTER - 1);
   localparam logic [CNT_W-1:0] STAGE_TC = CNT_W'(STAGE_DELAY - 1);
   localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(SW_HOLD - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

   seq_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
   logic                  done_q, done_d;
   logic                  lost_q, lost_d;
   logic                  lock_s;
   logic                  lock_drop;

   sync_2ff u_lock_sync (
      .clk   (clk),
      .rst_n (reset_n),
      .d     (bus.pll_locked),
      .q     (lock_s)
   );

   assign lock_drop = !lock_s && (state_q == RELEASE || state_q == RUN);

   // Next-state, counter and output decode; lock loss outranks sw reset.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      rst_out_d = rst_out_q;
      done_d    = done_q;
      lost_d    = lost_q;

      if (lock_drop) begin
         lost_d = 1'b1;
      end else if (bus.clear_lost) begin
         lost_d = 1'b0;
      end

      if (lock_drop && REARM_ON_LOSS != 0) begin
         state_d   = WAIT_LOCK;
         cnt_d     = '0;
         idx_d     = '0;
         rst_out_d = '0;
         done_d    = 1'b0;
      end else if (bus.sw_reset && state_q != HOLD) begin
         state_d   = HOLD;
         cnt_d     = '0;
         idx_d     = '0;
         rst_out_d = '0;
         done_d    = 1'b0;
      end else begin
         unique case (state_q)
            WAIT_LOCK: begin
               rst_out_d = '0;
               done_d    = 1'b0;
               if (!lock_s) begin
                  cnt_d = '0;
               end else if (cnt_q == LOCK_TC) begin
                  state_d = RELEASE;
                  cnt_d   = '0;
                  idx_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            RELEASE: begin
               if (cnt_q == STAGE_TC) begin
                  cnt_d = '0;
                  for (int i = 0; i < NUM_STAGES; i++) begin
                     if (IDX_W'(i) == idx_q) rst_out_d[i] = 1'b1;
                  end
                  // idx saturates at the last stage; RUN takes over from there.
                  if (idx_q == IDX_LAST) begin
                     state_d = RUN;
                     done_d  = 1'b1;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            RUN: begin
               state_d = RUN;
            end
            HOLD: begin
               rst_out_d = '0;
               done_d    = 1'b0;
               if (bus.sw_reset) begin
                  cnt_d = '0;
               end else if (cnt_q == HOLD_TC) begin
                  state_d = WAIT_LOCK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = WAIT_LOCK;
            end
         endcase
      end
   end

   // State, counters and every output flop; outputs come straight from here.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= WAIT_LOCK;
         cnt_q     <= '0;
         idx_q     <= '0;
         rst_out_q <= '0;
         done_q    <= 1'b0;
         lost_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         rst_out_q <= rst_out_d;
         done_q    <= done_d;
         lost_q    <= lost_d;
      end
   end

   assign bus.rst_n_out = rst_out_q;
   assign bus.done      = done_q;
   assign bus.state     = state_q;
   assign bus.lock_lost = lost_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: two instances (re-arm on / off) share stimulus.
// Edges are numbered from the last edge before pll_locked rises.
module tb_reset_sequencer;
   import reset_sequencer_pkg::*;

   localparam int NS  = 3;
   localparam int SD  = 8;
   localparam int LF  = 4;
   localparam int SWH = 5;

   localparam int S_WAIT = 0;
   localparam int S_REL  = 1;
   localparam int S_RUN  = 2;
   localparam int S_HOLD = 3;

   logic clk = 1'b0;
   logic reset_n;
   logic pll = 1'b0;
   logic sw  = 1'b0;
   logic clr = 1'b0;

   always #5 clk = ~clk;

   reset_sequencer_if #(.NUM_STAGES(NS)) if_a ();
   reset_sequencer_if #(.NUM_STAGES(NS)) if_b ();

   assign if_a.pll_locked = pll;
   assign if_a.sw_reset   = sw;
   assign if_a.clear_lost = clr;
   assign if_b.pll_locked = pll;
   assign if_b.sw_reset   = sw;
   assign if_b.clear_lost = clr;

   reset_sequencer #(.NUM_STAGES(NS), .STAGE_DELAY(SD), .LOCK_FILTER(LF),
                     .SW_HOLD(SWH), .REARM_ON_LOSS(1)) dut_a (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (if_a.slave)
   );

   reset_sequencer #(.NUM_STAGES(NS), .STAGE_DELAY(SD), .LOCK_FILTER(LF),
                     .SW_HOLD(SWH), .REARM_ON_LOSS(0)) dut_b (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (if_b.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: lock history, run length of lock highs, elapsed
   // release time (stages released = elapsed / SD), hold time, sticky flag.
   int m_ph[2];
   int m_run[2];
   int m_t[2];
   int m_h[2];
   int m_k[2];
   int m_lost[2];
   bit s1, s2;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      s1 = 1'b0;
      s2 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_ph[i] = S_WAIT; m_run[i] = 0; m_t[i] = 0;
         m_h[i] = 0; m_k[i] = 0; m_lost[i] = 0;
      end
   endtask

   task automatic model_edge(input int id, input bit ls, input bit swv, input bit clrv);
      bit rearm;
      bit loss;
      rearm = (id == 0);
      loss  = !ls && (m_ph[id] == S_REL || m_ph[id] == S_RUN);
      if (loss) m_lost[id] = 1;
      else if (clrv) m_lost[id] = 0;
      if (loss && rearm) begin
         m_ph[id] = S_WAIT; m_run[id] = 0; m_k[id] = 0;
      end else if (swv && m_ph[id] != S_HOLD) begin
         m_ph[id] = S_HOLD; m_h[id] = 0; m_k[id] = 0;
      end else begin
         case (m_ph[id])
            S_WAIT: begin
               m_run[id] = ls ? m_run[id] + 1 : 0;
               if (m_run[id] == LF) begin
                  m_ph[id] = S_REL; m_t[id] = 0; m_run[id] = 0;
               end
            end
            S_REL: begin
               m_t[id]++;
               m_k[id] = m_t[id] / SD;
               if (m_k[id] >= NS) begin
                  m_k[id] = NS; m_ph[id] = S_RUN;
               end
            end
            S_HOLD: begin
               if (swv) m_h[id] = 0;
               else begin
                  m_h[id]++;
                  if (m_h[id] == SWH) begin
                     m_ph[id] = S_WAIT; m_run[id] = 0;
                  end
               end
            end
            default: ;
         endcase
      end
   endtask

   function automatic int m_rst(input int id);
      return (1 << m_k[id]) - 1;
   endfunction

   task automatic cmp_all();
      chk("a_rst_n_out", int'(if_a.rst_n_out), m_rst(0));
      chk("a_done",      int'(if_a.done),      int'(m_ph[0] == S_RUN));
      chk("a_state",     int'(if_a.state),     m_ph[0]);
      chk("a_lock_lost", int'(if_a.lock_lost), m_lost[0]);
      chk("b_rst_n_out", int'(if_b.rst_n_out), m_rst(1));
      chk("b_done",      int'(if_b.done),      int'(m_ph[1] == S_RUN));
      chk("b_state",     int'(if_b.state),     m_ph[1]);
      chk("b_lock_lost", int'(if_b.lock_lost), m_lost[1]);
   endtask

   // One clock: drive at negedge, advance the model at the edge, compare.
   task automatic cyc(input bit p, input bit s, input bit c);
      bit ls;
      pll = p; sw = s; clr = c;
      @(posedge clk);
      ls = s2; s2 = s1; s1 = p;
      model_edge(0, ls, s, c);
      model_edge(1, ls, s, c);
      @(negedge clk);
      cmp_all();
   endtask

   // Async reset from a negedge; outputs must clear without any clock edge.
   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      chk("async_rst_a_out",   int'(if_a.rst_n_out), 0);
      chk("async_rst_a_state", int'(if_a.state),     S_WAIT);
      chk("async_rst_a_lost",  int'(if_a.lock_lost), 0);
      chk("async_rst_b_out",   int'(if_b.rst_n_out), 0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic wait_done_a(input int budget);
      int i;
      i = 0;
      while (i < budget && !if_a.done) begin
         cyc(1'b1, 1'b0, 1'b0);
         i++;
      end
      chk("done_a_within_budget", int'(if_a.done), 1);
   endtask

   typedef struct {
      int n;
      bit pll;
      bit sw;
      bit clr;
      int rst;
      int done;
      int st;
      int lost;
   } tv_t;

   tv_t tv[15];

   initial begin
      #1000000;
      $display("FAIL global_timeout: got 0, expected 1");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      bit seen;
      bit p;

      reset_n = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      cmp_all();
      reset_n = 1'b1;

      // Power-up, then a sw_reset pulse in RUN and the re-filtered restart.
      tv[0]  = '{1,  1'b0, 1'b0, 1'b0, 0, 0, S_WAIT, 0};
      tv[1]  = '{5,  1'b1, 1'b0, 1'b0, 0, 0, S_WAIT, 0};
      tv[2]  = '{1,  1'b1, 1'b0, 1'b0, 0, 0, S_REL,  0};
      tv[3]  = '{7,  1'b1, 1'b0, 1'b0, 0, 0, S_REL,  0};
      tv[4]  = '{1,  1'b1, 1'b0, 1'b0, 1, 0, S_REL,  0};
      tv[5]  = '{7,  1'b1, 1'b0, 1'b0, 1, 0, S_REL,  0};
      tv[6]  = '{1,  1'b1, 1'b0, 1'b0, 3, 0, S_REL,  0};
      tv[7]  = '{7,  1'b1, 1'b0, 1'b0, 3, 0, S_REL,  0};
      tv[8]  = '{1,  1'b1, 1'b0, 1'b0, 7, 1, S_RUN,  0};
      tv[9]  = '{5,  1'b1, 1'b0, 1'b0, 7, 1, S_RUN,  0};
      tv[10] = '{1,  1'b1, 1'b1, 1'b0, 0, 0, S_HOLD, 0};
      tv[11] = '{4,  1'b1, 1'b0, 1'b0, 0, 0, S_HOLD, 0};
      tv[12] = '{1,  1'b1, 1'b0, 1'b0, 0, 0, S_WAIT, 0};
      tv[13] = '{11, 1'b1, 1'b0, 1'b0, 0, 0, S_REL,  0};
      tv[14] = '{1,  1'b1, 1'b0, 1'b0, 1, 0, S_REL,  0};

      for (int r = 0; r < 15; r++) begin
         for (int j = 0; j < tv[r].n; j++) cyc(tv[r].pll, tv[r].sw, tv[r].clr);
         chk($sformatf("tv%0d_a_rst", r),   int'(if_a.rst_n_out), tv[r].rst);
         chk($sformatf("tv%0d_a_done", r),  int'(if_a.done),      tv[r].done);
         chk($sformatf("tv%0d_a_state", r), int'(if_a.state),     tv[r].st);
         chk($sformatf("tv%0d_a_lost", r),  int'(if_a.lock_lost), tv[r].lost);
         chk($sformatf("tv%0d_b_rst", r),   int'(if_b.rst_n_out), tv[r].rst);
         chk($sformatf("tv%0d_b_state", r), int'(if_b.state),     tv[r].st);
      end

      // Lock glitch: high 3, low 1, then steady; release 14 edges after edge 4.
      do_reset();
      cyc(1'b0, 1'b0, 1'b0);
      repeat (3) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cnt  = 0;
      seen = 1'b0;
      while (!seen && cnt < 40) begin
         cyc(1'b1, 1'b0, 1'b0);
         cnt++;
         if (cnt == 5) chk("glitch_still_waiting", int'(if_a.state), S_WAIT);
         seen = if_a.rst_n_out[0];
      end
      chk("glitch_release_delay", cnt, 14);

      // One-cycle lock drop in RUN: a re-arms, b only flags it.
      wait_done_a(60);
      cyc(1'b0, 1'b0, 1'b0);
      chk("loss_k0_a_rst", int'(if_a.rst_n_out), 7);
      cyc(1'b1, 1'b0, 1'b0);
      chk("loss_k1_a_rst", int'(if_a.rst_n_out), 7);
      cyc(1'b1, 1'b0, 1'b0);
      chk("loss_a_rst",   int'(if_a.rst_n_out), 0);
      chk("loss_a_done",  int'(if_a.done),      0);
      chk("loss_a_state", int'(if_a.state),     S_WAIT);
      chk("loss_a_lost",  int'(if_a.lock_lost), 1);
      chk("loss_b_rst",   int'(if_b.rst_n_out), 7);
      chk("loss_b_state", int'(if_b.state),     S_RUN);
      chk("loss_b_lost",  int'(if_b.lock_lost), 1);
      wait_done_a(60);
      chk("rerun_a_rst", int'(if_a.rst_n_out), 7);
      cyc(1'b1, 1'b0, 1'b1);
      chk("clear_a_lost", int'(if_a.lock_lost), 0);
      chk("clear_b_lost", int'(if_b.lock_lost), 0);

      // sw_reset coinciding with lock loss in RELEASE.
      do_reset();
      cyc(1'b0, 1'b0, 1'b0);
      repeat (8) cyc(1'b1, 1'b0, 1'b0);
      chk("pre_coinc_a_state", int'(if_a.state), S_REL);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      chk("coinc_a_state", int'(if_a.state),     S_WAIT);
      chk("coinc_a_lost",  int'(if_a.lock_lost), 1);
      chk("coinc_b_state", int'(if_b.state),     S_HOLD);
      chk("coinc_b_lost",  int'(if_b.lock_lost), 1);
      cnt = 0;
      while (if_a.rst_n_out != 3'b001 && cnt < 80) begin
         cyc(1'b1, 1'b0, 1'b0);
         cnt++;
      end
      chk("mid_release_a_rst",   int'(if_a.rst_n_out), 1);
      chk("mid_release_a_state", int'(if_a.state),     S_REL);
      do_reset();

      // Randomised soak against the model.
      p = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (p) p = ($urandom_range(0, 59) != 0);
         else   p = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 999) == 0) do_reset();
         else cyc(p, $urandom_range(0, 79) == 0, $urandom_range(0, 9) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
